// File: rtl/imem_loader.sv
`default_nettype none
// -----------------------------------------------------------------------------
// imem_loader : streams 32-bit words into the byte-wide instruction memory
// Rev 1.0
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_WORD = 3'd1,
    S_WRITE     = 3'd2,
    S_DONE      = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] c_mem_end = (ADDR_W+1)'(MEM_SIZE);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_byte_idx;
  logic              r_last;

  logic [ADDR_W:0]   w_addr_end;
  logic              w_overflow;
  logic [1:0]        w_next_idx;

  // One extra bit so a word straddling the top of the address space is caught
  assign w_addr_end = {1'b0, r_addr} + (ADDR_W+1)'(4);
  assign w_overflow = w_addr_end > c_mem_end;
  assign w_next_idx = r_byte_idx + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_byte_idx <= '0;
      r_last     <= 1'b0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_stall  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            cpu_stall <= 1'b1;
            if (base_addr[1:0] != 2'b00) begin
              r_state  <= S_ERROR;
              error    <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else begin
              r_state    <= S_WAIT_WORD;
              r_addr     <= base_addr;
              word_count <= '0;
              error      <= 1'b0;
              busy       <= 1'b1;
              in_ready   <= 1'b1;
            end
          end
        end
        S_WAIT_WORD: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (w_overflow) begin
              r_state <= S_ERROR;
              error   <= 1'b1;
              busy    <= 1'b0;
            end else begin
              // Byte 0 goes out straight from the handshake; the rest from r_data
              r_state    <= S_WRITE;
              r_data     <= in_data;
              r_last     <= in_last;
              r_byte_idx <= 2'd0;
              mem_we     <= 1'b1;
              mem_addr   <= r_addr;
              mem_wdata  <= in_data[7:0];
            end
          end
        end
        S_WRITE: begin
          if (r_byte_idx == 2'd3) begin
            r_addr <= r_addr + ADDR_W'(4);
            if (word_count != {CNT_W{1'b1}}) begin
              word_count <= word_count + CNT_W'(1);
            end
            if (r_last) begin
              r_state   <= S_DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              cpu_stall <= 1'b0;
            end else begin
              r_state  <= S_WAIT_WORD;
              in_ready <= 1'b1;
            end
          end else begin
            r_byte_idx <= w_next_idx;
            mem_we     <= 1'b1;
            mem_addr   <= mem_addr + ADDR_W'(1);
            mem_wdata  <= r_data[{w_next_idx, 3'b000} +: 8];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_imem_loader : randomized, model-checked bench for imem_loader
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_imem_loader;
  localparam int MEM_SIZE = 16;
  localparam int ADDR_W   = 32;
  localparam int CNT_W    = 16;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, in_last;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       in_data;
  logic              in_ready, mem_we, cpu_stall, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [CNT_W-1:0]  word_count;

  imem_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_stall(cpu_stall), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Observed activity, captured at the falling edge
  logic [ADDR_W-1:0] wa_q[$];
  logic [7:0]        wd_q[$];
  int                wc_q[$];
  logic [7:0]        img[MEM_SIZE];
  bit                rdy_log[0:4095];
  bit                stall_log[0:4095];
  int                done_cnt, done_cyc;
  logic              stall_at_done, busy_at_done;
  logic [CNT_W-1:0]  wc_at_done;

  // Reference: expected write list and words of the current load
  logic [ADDR_W-1:0] ea_q[$];
  logic [7:0]        ed_q[$];
  logic [31:0]       wbuf[8];

  always @(negedge clk) begin
    if (cyc < 4096) begin
      rdy_log[cyc]   = in_ready;
      stall_log[cyc] = cpu_stall;
    end
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
      if (mem_addr < MEM_SIZE) img[mem_addr] = mem_wdata;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc      = cyc;
      stall_at_done = cpu_stall;
      busy_at_done  = busy;
      wc_at_done    = word_count;
    end
  end

  // Plain arithmetic view of a load: word i occupies bytes base+4i .. base+4i+3,
  // little-endian; the first word that would run past MEM_SIZE aborts the load.
  function automatic void model_load(input logic [ADDR_W-1:0] base, input int n,
                                     output int exp_words, output bit exp_err);
    longint a;
    ea_q.delete(); ed_q.delete();
    exp_words = 0; exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = longint'(base) + longint'(4 * i);
      if (a + 4 > longint'(MEM_SIZE)) begin
        exp_err = 1'b1;
        return;
      end
      for (int k = 0; k < 4; k++) begin
        ea_q.push_back(ADDR_W'(a + k));
        ed_q.push_back(wbuf[i][8*k +: 8]);
      end
      exp_words++;
    end
  endfunction

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    done_cnt = 0; done_cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers a word until accepted; returns at the falling edge after the handshake
  task automatic send_word(input logic [31:0] d, input bit l, input int gap, output int hs);
    hs = -1;
    repeat (gap) @(negedge clk);
    in_data = d; in_last = l; in_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (in_ready === 1'b1) begin
        hs = cyc;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (hs < 0) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: in_ready=%b required 1 within 60 cycles", in_ready);
    end
  endtask

  task automatic wait_end(output bit got_done, output bit got_err);
    got_done = 1'b0; got_err = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (done === 1'b1) begin got_done = 1'b1; break; end
      if (error === 1'b1) begin got_err = 1'b1; break; end
      @(negedge clk);
    end
    if (!got_done && !got_err) begin
      checks++; errors++;
      $display("FAIL end_timeout: done=%b error=%b required done or error within 60 cycles", done, error);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, mem_we, cpu_stall, busy, done, error, mem_addr, mem_wdata, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b stall=%b busy=%b done=%b err=%b addr=%h wdata=%h wc=%0d required all 0",
               in_ready, mem_we, cpu_stall, busy, done, error, mem_addr, mem_wdata, word_count);
    end
  endtask

  task automatic test_basic();
    int h0, h1, ew; bit ee, gd, ge;
    do_reset(); clear_logs();
    wbuf[0] = 32'h12345678; wbuf[1] = 32'hAABBCCDD;
    model_load('0, 2, ew, ee);
    do_start('0);
    send_word(wbuf[0], 1'b0, 0, h0);
    send_word(wbuf[1], 1'b1, 0, h1);
    wait_end(gd, ge);
    repeat (3) @(negedge clk);
    checks++;
    if (wa_q.size() !== ea_q.size()) begin
      errors++; $display("FAIL basic_nwrites: got %0d required %0d", wa_q.size(), ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
        errors++; $display("FAIL basic_write[%0d]: got (%0h,%0h) required (%0h,%0h)", i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt); end
    checks++;
    if (wc_at_done !== CNT_W'(2)) begin errors++; $display("FAIL basic_word_count: got %0d required 2", wc_at_done); end
    checks++;
    if (stall_at_done !== 1'b0 || busy_at_done !== 1'b0 || stall_log[done_cyc-1] !== 1'b1) begin
      errors++; $display("FAIL basic_stall_release: stall@done=%b busy@done=%b stall_before=%b required 0,0,1",
                         stall_at_done, busy_at_done, stall_log[done_cyc-1]);
    end
    checks++;
    if ({img[3], img[2], img[1], img[0]} !== 32'h12345678) begin
      errors++; $display("FAIL basic_fetch_pc0: got %h required 12345678", {img[3], img[2], img[1], img[0]});
    end
    checks++;
    if (h1 !== h0 + 5) begin errors++; $display("FAIL throughput_next_hs: got %0d required %0d", h1, h0 + 5); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= wc_q.size() || wc_q[k] !== h0 + 1 + k || rdy_log[h0+1+k] !== 1'b0) begin
        errors++; $display("FAIL throughput_byte%0d: we_cycle=%0d ready=%b required cycle %0d ready 0",
                           k, (k < wc_q.size()) ? wc_q[k] : -1, rdy_log[h0+1+k], h0 + 1 + k);
      end
    end
    checks++;
    if (rdy_log[h0+5] !== 1'b1) begin errors++; $display("FAIL throughput_ready_back: got %b required 1", rdy_log[h0+5]); end
  endtask

  task automatic test_backpressure();
    int h, ew; bit ee, gd, ge;
    clear_logs();
    wbuf[0] = $urandom;
    model_load(ADDR_W'(4), 1, ew, ee);
    do_start(ADDR_W'(4));
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (mem_we !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL backpressure_hold[%0d]: we=%b rdy=%b busy=%b required 0,1,1", i, mem_we, in_ready, busy);
      end
      @(negedge clk);
    end
    send_word(wbuf[0], 1'b1, 0, h);
    wait_end(gd, ge);
    checks++;
    if (wa_q.size() !== ea_q.size()) begin
      errors++; $display("FAIL backpressure_nwrites: got %0d required %0d", wa_q.size(), ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
        errors++; $display("FAIL backpressure_write[%0d]: got (%0h,%0h) required (%0h,%0h)", i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int h, ew; bit ee;
    clear_logs();
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    model_load(ADDR_W'(8), 3, ew, ee);
    do_start(ADDR_W'(8));
    send_word(wbuf[0], 1'b0, 0, h);
    send_word(wbuf[1], 1'b0, 0, h);
    send_word(wbuf[2], 1'b1, 0, h);
    checks++;
    if (error !== 1'b1 || cpu_stall !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || word_count !== CNT_W'(2)) begin
      errors++; $display("FAIL overflow_status: err=%b stall=%b busy=%b rdy=%b wc=%0d required 1,1,0,0,2",
                         error, cpu_stall, busy, in_ready, word_count);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (wa_q.size() !== ea_q.size() || done_cnt !== 0 || error !== 1'b1 || cpu_stall !== 1'b1) begin
      errors++; $display("FAIL overflow_after: writes=%0d done=%0d err=%b stall=%b required %0d,0,1,1",
                         wa_q.size(), done_cnt, error, cpu_stall, ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
        errors++; $display("FAIL overflow_write[%0d]: got (%0h,%0h) required (%0h,%0h)", i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    int h, ew; bit ee, gd, ge;
    do_reset(); clear_logs();
    do_start(ADDR_W'(2));
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || cpu_stall !== 1'b1) begin
      errors++; $display("FAIL misaligned_status: err=%b rdy=%b busy=%b stall=%b required 1,0,0,1", error, in_ready, busy, cpu_stall);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wa_q.size() !== 0) begin errors++; $display("FAIL misaligned_nowrite: got %0d writes required 0", wa_q.size()); end
    wbuf[0] = $urandom;
    model_load('0, 1, ew, ee);
    do_start('0);
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL misaligned_restart: err=%b rdy=%b busy=%b required 0,1,1", error, in_ready, busy);
    end
    send_word(wbuf[0], 1'b1, 0, h);
    wait_end(gd, ge);
    checks++;
    if (wa_q.size() !== ea_q.size() || gd !== 1'b1) begin
      errors++; $display("FAIL misaligned_reload: writes=%0d done=%b required %0d,1", wa_q.size(), gd, ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
        errors++; $display("FAIL misaligned_write[%0d]: got (%0h,%0h) required (%0h,%0h)", i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int h;
    do_reset(); clear_logs();
    wbuf[0] = $urandom;
    do_start('0);
    send_word(wbuf[0], 1'b1, 0, h);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(1)) begin
      errors++; $display("FAIL midreset_byte1: we=%b addr=%h required 1,1", mem_we, mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, cpu_stall, busy, done, error, mem_addr, mem_wdata, word_count} !== '0) begin
      errors++; $display("FAIL midreset_outputs: rdy=%b we=%b stall=%b busy=%b done=%b err=%b addr=%h wdata=%h wc=%0d required all 0",
                         in_ready, mem_we, cpu_stall, busy, done, error, mem_addr, mem_wdata, word_count);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (wa_q.size() !== 2 || done_cnt !== 0) begin
      errors++; $display("FAIL midreset_after: writes=%0d done=%0d required 2,0", wa_q.size(), done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int h, ew; bit ee, gd, ge;
    clear_logs();
    wbuf[0] = $urandom; wbuf[1] = $urandom;
    model_load(ADDR_W'(4), 2, ew, ee);
    do_start(ADDR_W'(4));
    do_start(ADDR_W'(2));
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ignore_start_wait: err=%b busy=%b rdy=%b required 0,1,1", error, busy, in_ready);
    end
    send_word(wbuf[0], 1'b0, 0, h);
    do_start(ADDR_W'(8));
    send_word(wbuf[1], 1'b1, 0, h);
    wait_end(gd, ge);
    checks++;
    if (wa_q.size() !== ea_q.size() || gd !== 1'b1 || word_count !== CNT_W'(2)) begin
      errors++; $display("FAIL ignore_start_result: writes=%0d done=%b wc=%0d required %0d,1,2", wa_q.size(), gd, word_count, ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
        errors++; $display("FAIL ignore_start_write[%0d]: got (%0h,%0h) required (%0h,%0h)", i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int h, ew, n, nsend; bit ee, gd, ge;
    logic [ADDR_W-1:0] b;
    for (int it = 0; it < 30; it++) begin
      clear_logs();
      b = ADDR_W'(4 * $urandom_range(0, 5));
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      model_load(b, n, ew, ee);
      nsend = ee ? ew + 1 : n;
      do_start(b);
      for (int i = 0; i < nsend; i++) begin
        send_word(wbuf[i], (i == n - 1), int'($urandom_range(0, 2)), h);
      end
      wait_end(gd, ge);
      checks++;
      if (ge !== ee || gd !== !ee || word_count !== CNT_W'(ew) || wa_q.size() !== ea_q.size()) begin
        errors++; $display("FAIL random[%0d] base=%0d n=%0d: err=%b done=%b wc=%0d writes=%0d required %b,%b,%0d,%0d",
                           it, b, n, ge, gd, word_count, wa_q.size(), ee, !ee, ew, ea_q.size());
      end
      for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
        checks++;
        if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
          errors++; $display("FAIL random[%0d]_write[%0d]: got (%0h,%0h) required (%0h,%0h)", it, i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_misaligned();
    test_reset_mid_write();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory byte array that the fetch stage reads.
- Accepts 32-bit instruction words over a valid/ready stream and writes them one byte per cycle into the byte-wide instruction memory.
- Byte order matches fetch assembly: the word at address A is {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
- Holds the fetch stage stalled while a program is loading, then releases it.

Parameters:
- MEM_SIZE, 1024: instruction memory size in bytes. Must be a multiple of 4.
- ADDR_W, 32: width of the memory address and base address.
- CNT_W, 16: width of the loaded-word counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins a load at base_addr. Honoured only in IDLE or ERROR.
- base_addr  input  ADDR_W  byte address of the first word. Must be 4-byte aligned.
- in_valid  input  1  a word is available on in_data.
- in_data  input  32  instruction word.
- in_last  input  1  qualifies in_data as the final word of the program.
- in_ready  output  1  loader can accept a word this cycle.
- mem_we  output  1  byte write enable to instruction memory.
- mem_addr  output  ADDR_W  byte address for the write.
- mem_wdata  output  8  byte to write.
- cpu_stall  output  1  hold the fetch PC. Drives the fetch stage's stall input (ORed with hazard stall at top level).
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when the last byte has been written.
- error  output  1  sticky error flag.
- word_count  output  CNT_W  number of words fully written in the current or last load.

Behaviour:
- All outputs are registered.
- Reset (synchronous, at any time including mid-load):
  - state goes to IDLE.
  - in_ready, mem_we, cpu_stall, busy, done and error go to 0.
  - mem_addr, mem_wdata and word_count go to 0.
  - Internal addr, data and byte_idx are cleared.
- States: IDLE, WAIT_WORD, WRITE, DONE, ERROR.
- IDLE:
  - On start: if base_addr[1:0] != 0, go to ERROR. Otherwise addr <= base_addr, word_count <= 0, go to WAIT_WORD.
  - busy and cpu_stall are 1 from the cycle after start.
- WAIT_WORD:
  - in_ready = 1.
  - Handshake: a word transfers on a cycle where in_valid && in_ready are both 1.
  - If addr + 4 > MEM_SIZE at the handshake: go to ERROR with no write (overflow).
  - Otherwise latch in_data and in_last, set byte_idx = 0, go to WRITE.
  - in_valid low means stay in WAIT_WORD indefinitely.
- WRITE:
  - in_ready = 0.
  - For byte_idx 0..3, one per cycle: mem_we = 1, mem_addr = addr + byte_idx, mem_wdata = data[8*byte_idx+7 : 8*byte_idx].
  - After byte 3: addr += 4, word_count += 1. Go to DONE if the latched last flag is set, else WAIT_WORD.
  - mem_we = 0 in every other state.
- Timing:
  - Word handshake in cycle N gives byte writes in cycles N+1..N+4.
  - The next handshake is possible at cycle N+5 at the earliest, so throughput is 1 word per 5 cycles.
- DONE:
  - done = 1 for exactly one cycle.
  - busy and cpu_stall drop to 0 in that same cycle.
  - Next state is IDLE.
- ERROR:
  - error = 1 and cpu_stall = 1, held so the CPU never runs a partial program.
  - busy = 0, in_ready = 0.
  - Cleared only by reset or a new start, which re-runs the IDLE start checks.
- start during WAIT_WORD or WRITE is ignored.
- in_last on a word that overflows goes to ERROR, not DONE.
- Address arithmetic is unsigned, ADDR_W bits. The overflow check uses a width of ADDR_W+1 so wrap-around cannot be missed.
- word_count saturates at all-ones; it does not wrap.

Test Plan:
1. Reset, start with base_addr=0, send words 0x12345678 (in_last=0) and 0xAABBCCDD (in_last=1) with in_valid held high.
   - Required writes in order: (0,78), (1,56), (2,34), (3,12), (4,DD), (5,CC), (6,BB), (7,AA).
   - done pulses once, word_count=2, cpu_stall falls with done.
   - A fetch at PC=0 then returns 0x12345678.
2. Throughput: handshake at cycle N gives mem_we high for N+1..N+4. in_ready is low during those cycles and high again at N+5.
3. Back-pressure: in_valid low for 10 cycles in WAIT_WORD.
   - No mem_we, state held, in_ready stays 1.
   - A later word is written correctly.
4. Overflow: MEM_SIZE=16, base_addr=8, send 3 words.
   - Words 1 and 2 are written to bytes 8..15.
   - The third handshake raises error with no further mem_we; cpu_stall stays 1; word_count=2.
5. Misaligned start: base_addr=0x2 gives error=1 the cycle after start, with no in_ready and no writes. A new start with base_addr=0 clears error and loads normally.
6. Reset mid-WRITE, asserted after byte 1 is written:
   - Next cycle all outputs are 0 and no further mem_we.
   - start is ignored while busy, and its byte sequence is unaffected.
